servo_pwm_filter: RTL and testbench

Multi-channel servo/RC pulse input conditioner, the parametrised successor to the single-input servo filter. Each channel synchronises a raw pulse input, rejects glitches shorter than a programmable debounce length, and measures the high time of each clean pulse in `clk` cycles. Widths inside a legal window are published with a one-cycle strobe; out-of-window pulses raise a sticky error. Sits between the board pins and the servo/position control logic.

---
 rtl/servo_pwm_filter_pkg.sv | 13 +
 rtl/servo_pwm_filter_ch.sv | 135 +++++++++++++
 rtl/servo_pwm_filter.sv | 42 ++++
 tb/tb_servo_pwm_filter.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/servo_pwm_filter_pkg.sv
// Shared definitions for the servo pulse conditioner: measurement FSM encoding
// and synchroniser depth.
package servo_pwm_filter_pkg;

    localparam int SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MEAS = 2'd1,
        OVER = 2'd2
    } meas_state_e;

endpackage

// File: rtl/servo_pwm_filter_ch.sv
// One servo input channel: synchroniser, debounce filter, high-time measurement
// FSM with legal-window check, last-width register and sticky error.
module servo_pwm_filter_ch
    import servo_pwm_filter_pkg::*;
#(
    parameter int DEB_CYCLES = 4,
    parameter int CNT_W      = 16,
    parameter int MIN_W      = 1000,
    parameter int MAX_W      = 2000
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             enable_i,
    input  logic             in_i,
    input  logic             err_clr_i,
    output logic             filt_o,
    output logic [CNT_W-1:0] width_o,
    output logic             valid_o,
    output logic             err_o
);

    localparam int               DEB_W    = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] MIN_C    = CNT_W'(MIN_W);
    localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(MAX_W);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   sync_lvl;
    logic [DEB_W-1:0]       deb_q, deb_d;
    logic                   filt_q, filt_d;
    meas_state_e            state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]       width_q, width_d;
    logic                   valid_q, valid_d;
    logic                   err_q, err_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Synchroniser runs even while disabled so re-enable sees a settled level.
    assign sync_d   = {sync_q[SYNC_STAGES-2:0], in_i};
    assign sync_lvl = sync_q[SYNC_STAGES-1];

    always_comb begin
        deb_d  = '0;
        filt_d = filt_q;
        if (!enable_i) begin
            filt_d = 1'b0;
        end else if (sync_lvl != filt_q) begin
            if (deb_q == DEB_LAST) begin
                filt_d = ~filt_q;
            end else begin
                deb_d = deb_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        width_d = width_q;
        valid_d = 1'b0;
        err_d   = err_q & ~err_clr_i;
        if (!enable_i) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (filt_q) begin
                        state_d = MEAS;
                        cnt_d   = CNT_W'(1);
                    end
                end
                MEAS: begin
                    if (!filt_q) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        // cnt can never exceed MAX_C here, so only the lower bound matters.
                        if (cnt_q >= MIN_C) begin
                            width_d = cnt_q;
                            valid_d = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else if (cnt_q == MAX_C) begin
                        state_d = OVER;
                        err_d   = 1'b1;
                    end else begin
                        cnt_d = sat_inc(cnt_q);
                    end
                end
                OVER: begin
                    if (!filt_q) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q  <= '0;
            deb_q   <= '0;
            filt_q  <= 1'b0;
            state_q <= IDLE;
            cnt_q   <= '0;
            width_q <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            deb_q   <= deb_d;
            filt_q  <= filt_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            width_q <= width_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign filt_o  = filt_q;
    assign width_o = width_q;
    assign valid_o = valid_q;
    assign err_o   = err_q;

endmodule

// File: rtl/servo_pwm_filter.sv
// Multi-channel servo pulse conditioner: N_CH independent channels sharing
// clock, reset and enable, with widths packed channel-major.
module servo_pwm_filter
    import servo_pwm_filter_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int DEB_CYCLES = 4,
    parameter int CNT_W      = 16,
    parameter int MIN_W      = 1000,
    parameter int MAX_W      = 2000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [N_CH-1:0]       in,
    input  logic [N_CH-1:0]       err_clr,
    output logic [N_CH-1:0]       filt,
    output logic [N_CH*CNT_W-1:0] width,
    output logic [N_CH-1:0]       valid,
    output logic [N_CH-1:0]       err
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        servo_pwm_filter_ch #(
            .DEB_CYCLES (DEB_CYCLES),
            .CNT_W      (CNT_W),
            .MIN_W      (MIN_W),
            .MAX_W      (MAX_W)
        ) u_ch (
            .clk_i     (clk),
            .rst_ni    (reset),
            .enable_i  (enable),
            .in_i      (in[i]),
            .err_clr_i (err_clr[i]),
            .filt_o    (filt[i]),
            .width_o   (width[i*CNT_W +: CNT_W]),
            .valid_o   (valid[i]),
            .err_o     (err[i])
        );
    end

endmodule

// File: tb/tb_servo_pwm_filter.sv
// Directed bench for servo_pwm_filter with hand-computed timing and widths.
module tb_servo_pwm_filter;

    localparam int N_CH       = 2;
    localparam int DEB_CYCLES = 4;
    localparam int CNT_W      = 16;
    localparam int MIN_W      = 1000;
    localparam int MAX_W      = 2000;

    logic                  clk     = 1'b0;
    logic                  reset   = 1'b0;
    logic                  enable  = 1'b0;
    logic [N_CH-1:0]       in_s    = '0;
    logic [N_CH-1:0]       err_clr = '0;
    logic [N_CH-1:0]       filt;
    logic [N_CH*CNT_W-1:0] width;
    logic [N_CH-1:0]       valid;
    logic [N_CH-1:0]       err;

    int n_cmp  = 0;
    int n_fail = 0;
    int vcnt0  = 0;
    int vcnt1  = 0;

    always #5 clk = ~clk;

    servo_pwm_filter #(
        .N_CH       (N_CH),
        .DEB_CYCLES (DEB_CYCLES),
        .CNT_W      (CNT_W),
        .MIN_W      (MIN_W),
        .MAX_W      (MAX_W)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .in      (in_s),
        .err_clr (err_clr),
        .filt    (filt),
        .width   (width),
        .valid   (valid),
        .err     (err)
    );

    always @(negedge clk) begin
        if (valid[0] === 1'b1) vcnt0++;
        if (valid[1] === 1'b1) vcnt1++;
    end

    function automatic logic [CNT_W-1:0] wch(input int ch);
        return width[ch*CNT_W +: CNT_W];
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_pulse(input int ch, input int w);
        in_s[ch] = 1'b1;
        tick(w);
        in_s[ch] = 1'b0;
        tick(10);
    endtask

    task automatic test_reset();
        reset  = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_s    = N_CH'($urandom_range(0, 3));
            err_clr = N_CH'($urandom_range(0, 3));
            tick(1);
            n_cmp++;
            if ({filt, valid, err, width} !== '0) begin
                n_fail++;
                $display("FAIL reset_hold: outputs=%h expected 0", {filt, valid, err, width});
            end
        end
        in_s    = '0;
        err_clr = '0;
        reset   = 1'b1;
        tick(20);
        n_cmp++;
        if ({filt, valid, err, width} !== '0 || vcnt0 != 0 || vcnt1 != 0) begin
            n_fail++;
            $display("FAIL reset_idle: outputs=%h vcnt=%0d/%0d expected 0", {filt, valid, err, width}, vcnt0, vcnt1);
        end
    endtask

    task automatic test_glitch();
        int v0;
        v0 = vcnt0;
        in_s[0] = 1'b1;
        tick(3);
        in_s[0] = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick(1);
            n_cmp++;
            if (filt[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL glitch_filt: cycle %0d filt=%b expected 0", i, filt[0]);
            end
        end
        n_cmp++;
        if (vcnt0 != v0 || err !== 2'b00) begin
            n_fail++;
            $display("FAIL glitch_quiet: valids=%0d err=%b expected 0 and 00", vcnt0 - v0, err);
        end
    endtask

    task automatic test_legal();
        int v0;
        v0 = vcnt0;
        in_s[0] = 1'b1;
        tick(5);
        n_cmp++;
        if (filt[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL legal_filt_early: filt=%b expected 0", filt[0]);
        end
        tick(1);
        n_cmp++;
        if (filt[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL legal_filt_rise: filt=%b expected 1", filt[0]);
        end
        tick(1500 - 6);
        in_s[0] = 1'b0;
        tick(6);
        n_cmp++;
        if (valid[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL legal_valid_early: valid=%b expected 0", valid[0]);
        end
        tick(1);
        n_cmp++;
        if (valid[0] !== 1'b1 || wch(0) !== 16'd1500) begin
            n_fail++;
            $display("FAIL legal_valid: valid=%b width=%0d expected 1 and 1500", valid[0], wch(0));
        end
        tick(1);
        n_cmp++;
        if (valid[0] !== 1'b0 || vcnt0 - v0 != 1 || err !== 2'b00) begin
            n_fail++;
            $display("FAIL legal_once: valid=%b count=%0d err=%b expected 0, 1, 00", valid[0], vcnt0 - v0, err);
        end
    endtask

    task automatic test_short();
        int v0;
        v0 = vcnt0;
        in_s[0] = 1'b1;
        tick(999);
        in_s[0] = 1'b0;
        tick(6);
        n_cmp++;
        if (err[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL short_err_early: err=%b expected 0", err[0]);
        end
        tick(1);
        n_cmp++;
        if (err[0] !== 1'b1 || valid[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL short_err: err=%b valid=%b expected 1 and 0", err[0], valid[0]);
        end
        tick(5);
        n_cmp++;
        if (vcnt0 != v0 || wch(0) !== 16'd1500) begin
            n_fail++;
            $display("FAIL short_width: valids=%0d width=%0d expected 0 and 1500", vcnt0 - v0, wch(0));
        end
        err_clr[0] = 1'b1;
        tick(1);
        err_clr[0] = 1'b0;
        n_cmp++;
        if (err[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL short_clr: err=%b expected 0", err[0]);
        end
    endtask

    task automatic test_boundaries();
        int v0;
        v0 = vcnt0;
        drive_pulse(0, 1000);
        n_cmp++;
        if (vcnt0 - v0 != 1 || wch(0) !== 16'd1000 || err[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL bound_min: valids=%0d width=%0d err=%b expected 1, 1000, 0", vcnt0 - v0, wch(0), err[0]);
        end
        drive_pulse(0, 2000);
        n_cmp++;
        if (vcnt0 - v0 != 2 || wch(0) !== 16'd2000 || err[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL bound_max: valids=%0d width=%0d err=%b expected 2, 2000, 0", vcnt0 - v0, wch(0), err[0]);
        end
    endtask

    task automatic test_long();
        int v0;
        v0 = vcnt0;
        in_s[0] = 1'b1;
        tick(2006);
        n_cmp++;
        if (err[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL long_err_early: err=%b expected 0", err[0]);
        end
        tick(1);
        n_cmp++;
        if (err[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL long_err_rise: err=%b expected 1", err[0]);
        end
        tick(2500 - 2007);
        in_s[0] = 1'b0;
        tick(12);
        n_cmp++;
        if (vcnt0 != v0 || err[0] !== 1'b1 || wch(0) !== 16'd2000 || filt[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL long_end: valids=%0d err=%b width=%0d filt=%b expected 0, 1, 2000, 0",
                     vcnt0 - v0, err[0], wch(0), filt[0]);
        end
    endtask

    task automatic test_clr_collision();
        err_clr[0] = 1'b1;
        tick(1);
        err_clr[0] = 1'b0;
        n_cmp++;
        if (err[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_plain: err=%b expected 0", err[0]);
        end
        in_s[0] = 1'b1;
        tick(500);
        in_s[0] = 1'b0;
        tick(6);
        err_clr[0] = 1'b1;
        tick(1);
        err_clr[0] = 1'b0;
        n_cmp++;
        if (err[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL clr_collide: err=%b expected 1", err[0]);
        end
        err_clr[0] = 1'b1;
        tick(1);
        err_clr[0] = 1'b0;
        tick(2);
    endtask

    task automatic test_back_to_back();
        int v0, v1;
        v0 = vcnt0;
        v1 = vcnt1;
        in_s[1] = 1'b1;
        tick(600);
        in_s[0] = 1'b1;
        tick(1200);
        in_s = 2'b00;
        tick(6);
        n_cmp++;
        if (valid !== 2'b00) begin
            n_fail++;
            $display("FAIL conc_early: valid=%b expected 00", valid);
        end
        tick(1);
        n_cmp++;
        if (valid !== 2'b11 || wch(0) !== 16'd1200 || wch(1) !== 16'd1800) begin
            n_fail++;
            $display("FAIL conc_valid: valid=%b w0=%0d w1=%0d expected 11, 1200, 1800", valid, wch(0), wch(1));
        end
        tick(2);
        n_cmp++;
        if (vcnt0 - v0 != 1 || vcnt1 - v1 != 1 || err !== 2'b00) begin
            n_fail++;
            $display("FAIL conc_once: valids=%0d/%0d err=%b expected 1/1, 00", vcnt0 - v0, vcnt1 - v1, err);
        end
    endtask

    task automatic test_abort_enable();
        int v0;
        v0 = vcnt0;
        in_s[0] = 1'b1;
        tick(800);
        enable = 1'b0;
        tick(3);
        n_cmp++;
        if (filt[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_en_filt: filt=%b expected 0", filt[0]);
        end
        in_s[0] = 1'b0;
        tick(5);
        enable = 1'b1;
        tick(15);
        n_cmp++;
        if (vcnt0 != v0 || err !== 2'b00 || wch(0) !== 16'd1200) begin
            n_fail++;
            $display("FAIL abort_en_quiet: valids=%0d err=%b width=%0d expected 0, 00, 1200", vcnt0 - v0, err, wch(0));
        end
        // Input already high when enable returns: counted from the re-enable edge.
        enable  = 1'b0;
        in_s[0] = 1'b1;
        tick(300);
        enable = 1'b1;
        tick(1200);
        in_s[0] = 1'b0;
        tick(7);
        n_cmp++;
        if (valid[0] !== 1'b1 || wch(0) !== 16'd1202) begin
            n_fail++;
            $display("FAIL enable_rise: valid=%b width=%0d expected 1 and 1202", valid[0], wch(0));
        end
        tick(5);
        drive_pulse(0, 1500);
        n_cmp++;
        if (vcnt0 - v0 != 2 || wch(0) !== 16'd1500 || err[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_en_next: valids=%0d width=%0d err=%b expected 2, 1500, 0", vcnt0 - v0, wch(0), err[0]);
        end
    endtask

    task automatic test_abort_reset();
        int v0;
        v0 = vcnt0;
        in_s[0] = 1'b1;
        tick(800);
        reset   = 1'b0;
        in_s[0] = 1'b0;
        #1;
        n_cmp++;
        if ({filt, valid, err, width} !== '0) begin
            n_fail++;
            $display("FAIL abort_rst_clear: outputs=%h expected 0", {filt, valid, err, width});
        end
        tick(3);
        reset = 1'b1;
        tick(15);
        n_cmp++;
        if (vcnt0 != v0 || err !== 2'b00 || wch(0) !== 16'd0) begin
            n_fail++;
            $display("FAIL abort_rst_quiet: valids=%0d err=%b width=%0d expected 0, 00, 0", vcnt0 - v0, err, wch(0));
        end
        drive_pulse(0, 1500);
        n_cmp++;
        if (vcnt0 - v0 != 1 || wch(0) !== 16'd1500 || err[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_rst_next: valids=%0d width=%0d err=%b expected 1, 1500, 0", vcnt0 - v0, wch(0), err[0]);
        end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_legal();
        test_short();
        test_boundaries();
        test_long();
        test_clr_collision();
        test_back_to_back();
        test_abort_enable();
        test_abort_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
